alu_decoder: RTL and testbench

//  Main-ALU control decoder for the single-cycle MIPS datapath.
//  - Maps the 2-bit ALUOp from the main control unit, plus the R-type Funct field,
//    to the 3-bit ALUControl code that drives the ALU.
//  - Decode path is purely combinational: zero-cycle latency, so the single-cycle

---
 rtl/alu_decoder.sv | 88 ++++++++
 tb/tb_alu_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_decoder.sv
// ALU control decoder for a single-cycle MIPS datapath.
//
// Turns the main decoder's ALUOp class and the R-type Funct field into the
// 3-bit ALUControl code for the ALU. The decode is purely combinational, so it
// adds no cycles to the datapath. A sticky flop remembers whether an
// unsupported ALUOp/Funct pair was present at any clock edge since reset.
//
// Ports:
//   clk          in   1  system clock
//   rst_n        in   1  asynchronous active-low reset
//   ALUOp        in   2  ALU operation class from the main decoder
//   Funct        in   6  instruction[5:0], R-type function field
//   ALUControl   out  3  ALU operation select (combinational)
//   IllegalOp    out  1  current ALUOp/Funct pair is unsupported (combinational)
//   IllegalSeen  out  1  sticky: IllegalOp was high at some clk edge since reset
module alu_decoder #(
  parameter logic [2:0] DEFAULT_CTRL = 3'b010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ALUOp,
  input  logic [5:0] Funct,
  output logic [2:0] ALUControl,
  output logic       IllegalOp,
  output logic       IllegalSeen
);

  // ALUOp classes
  localparam logic [1:0] OpMem    = 2'b00;
  localparam logic [1:0] OpBranch = 2'b01;
  localparam logic [1:0] OpRType  = 2'b10;

  // R-type function codes
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU control codes
  localparam logic [2:0] CtrlAnd = 3'b000;
  localparam logic [2:0] CtrlOr  = 3'b001;
  localparam logic [2:0] CtrlAdd = 3'b010;
  localparam logic [2:0] CtrlSub = 3'b110;
  localparam logic [2:0] CtrlSlt = 3'b111;

  logic [2:0] alu_control;
  logic       illegal_op;
  logic       illegal_seen_d, illegal_seen_q;

  // Defaults cover every unsupported combination, so no path can latch.
  always_comb begin
    alu_control = DEFAULT_CTRL;
    illegal_op  = 1'b0;
    case (ALUOp)
      OpMem:    alu_control = CtrlAdd;
      OpBranch: alu_control = CtrlSub;
      OpRType: begin
        case (Funct)
          FnAdd:   alu_control = CtrlAdd;
          FnSub:   alu_control = CtrlSub;
          FnAnd:   alu_control = CtrlAnd;
          FnOr:    alu_control = CtrlOr;
          FnSlt:   alu_control = CtrlSlt;
          default: illegal_op  = 1'b1;
        endcase
      end
      default: illegal_op = 1'b1;  // reserved ALUOp=11
    endcase
  end

  always_comb begin
    illegal_seen_d = illegal_seen_q | illegal_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen_q <= 1'b0;
    end else begin
      illegal_seen_q <= illegal_seen_d;
    end
  end

  assign ALUControl  = alu_control;
  assign IllegalOp   = illegal_op;
  assign IllegalSeen = illegal_seen_q;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: a directed vector table, hand-written
// reset sequences and a randomized run against a lookup-table reference model.
module tb_alu_decoder;

  logic       clk;
  logic       rst_n;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [2:0] alu_control;
  logic       illegal_op;
  logic       illegal_seen;

  int checks;
  int errors;
  bit seen_model;

  alu_decoder #(
    .DEFAULT_CTRL(3'b010)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ALUOp      (alu_op),
    .Funct      (funct),
    .ALUControl (alu_control),
    .IllegalOp  (illegal_op),
    .IllegalSeen(illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] op;
    logic [5:0] fn;
    logic [2:0] ctrl;
    logic       ill;
  } vec_t;

  vec_t vecs[$];

  // Supported R-type instructions and the ALU code each one needs.
  logic [5:0] rt_funct [5];
  logic [2:0] rt_ctrl  [5];

  function automatic void ref_decode(input logic [1:0] op, input logic [5:0] fn,
                                     output logic [2:0] ctrl, output logic ill);
    ctrl = 3'd2;
    ill  = 1'b1;
    if (op == 2'd0) begin
      ctrl = 3'd2;
      ill  = 1'b0;
    end else if (op == 2'd1) begin
      ctrl = 3'd6;
      ill  = 1'b0;
    end else if (op == 2'd2) begin
      for (int i = 0; i < 5; i++) begin
        if (rt_funct[i] == fn) begin
          ctrl = rt_ctrl[i];
          ill  = 1'b0;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (op=%0b funct=%06b t=%0t)",
               name, act, exp, alu_op, funct, $time);
    end
  endtask

  // Drive a pair, check the combinational outputs, then clock once and check the flag.
  task automatic apply_and_clock(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [2:0] exp_ctrl, input logic exp_ill,
                                 input string name);
    alu_op = op;
    funct  = fn;
    #1;
    check({name, "_ctrl"}, {5'd0, alu_control}, {5'd0, exp_ctrl});
    check({name, "_ill"}, {7'd0, illegal_op}, {7'd0, exp_ill});
    @(posedge clk);
    if (rst_n) seen_model = seen_model | exp_ill;
    #1;
    check({name, "_seen"}, {7'd0, illegal_seen}, {7'd0, seen_model});
  endtask

  initial begin
    logic [2:0] m_ctrl;
    logic       m_ill;
    logic [1:0] r_op;
    logic [5:0] r_fn;

    checks = 0;
    errors = 0;
    seen_model = 1'b0;
    rt_funct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rt_ctrl  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    vecs.push_back('{2'b00, 6'b000000, 3'b010, 1'b0});
    vecs.push_back('{2'b01, 6'b000000, 3'b110, 1'b0});
    vecs.push_back('{2'b00, 6'b111111, 3'b010, 1'b0});
    vecs.push_back('{2'b01, 6'b101010, 3'b110, 1'b0});
    vecs.push_back('{2'b10, 6'b100000, 3'b010, 1'b0});
    vecs.push_back('{2'b10, 6'b100010, 3'b110, 1'b0});
    vecs.push_back('{2'b10, 6'b100100, 3'b000, 1'b0});
    vecs.push_back('{2'b10, 6'b100101, 3'b001, 1'b0});
    vecs.push_back('{2'b10, 6'b101010, 3'b111, 1'b0});
    vecs.push_back('{2'b10, 6'b000000, 3'b010, 1'b1});
    vecs.push_back('{2'b11, 6'b000000, 3'b010, 1'b1});
    vecs.push_back('{2'b11, 6'b100000, 3'b010, 1'b1});
    vecs.push_back('{2'b10, 6'b100001, 3'b010, 1'b1});

    // Reset with no clock edge yet: flag must clear asynchronously.
    rst_n  = 1'b1;
    alu_op = 2'b10;
    funct  = 6'b000000;
    #1 rst_n = 1'b0;
    #1;
    check("reset_async_seen", {7'd0, illegal_seen}, 8'd0);
    check("reset_comb_ill", {7'd0, illegal_op}, 8'd1);
    check("reset_comb_ctrl", {5'd0, alu_control}, 8'd2);
    // Illegal op present at an edge while in reset must not set the flag.
    @(posedge clk);
    #1;
    check("reset_hold_seen", {7'd0, illegal_seen}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table; legal entries first keep the flag low until the illegal ones.
    foreach (vecs[i]) begin
      apply_and_clock(vecs[i].op, vecs[i].fn, vecs[i].ctrl, vecs[i].ill, $sformatf("vec%0d", i));
    end

    // Mid-cycle reset clears the flag at once; decode keeps tracking inputs.
    @(negedge clk);
    #2 rst_n = 1'b0;
    seen_model = 1'b0;
    #1;
    check("midreset_seen", {7'd0, illegal_seen}, 8'd0);
    alu_op = 2'b10;
    funct  = 6'b100100;
    #1;
    check("midreset_ctrl_and", {5'd0, alu_control}, 8'd0);
    funct  = 6'b101010;
    #1;
    check("midreset_ctrl_slt", {5'd0, alu_control}, 8'd7);
    @(negedge clk);
    rst_n = 1'b1;

    // Legal op keeps the flag low, one illegal edge sets it, legal op leaves it set.
    apply_and_clock(2'b00, 6'b000000, 3'b010, 1'b0, "seq_legal");
    check("seq_legal_zero", {7'd0, illegal_seen}, 8'd0);
    apply_and_clock(2'b11, 6'b000000, 3'b010, 1'b1, "seq_illegal");
    check("seq_illegal_one", {7'd0, illegal_seen}, 8'd1);
    apply_and_clock(2'b10, 6'b100010, 3'b110, 1'b0, "seq_sticky");
    check("seq_sticky_one", {7'd0, illegal_seen}, 8'd1);

    // Randomized run, with occasional resets so the flag is exercised repeatedly.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 31) == 0) begin
        #1 rst_n = 1'b0;
        seen_model = 1'b0;
        #1;
        check("rand_reset_seen", {7'd0, illegal_seen}, 8'd0);
        rst_n = 1'b1;
      end
      r_op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) r_fn = rt_funct[$urandom_range(0, 4)];
      else r_fn = 6'($urandom);
      // Bias toward legal traffic so the flag is not stuck high for most of the run.
      if (r_op == 2'b11 && $urandom_range(0, 3) != 0) r_op = 2'b10;
      ref_decode(r_op, r_fn, m_ctrl, m_ill);
      apply_and_clock(r_op, r_fn, m_ctrl, m_ill, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
